// File: rtl/alu_ctrl_pkg.sv
// ALU control stage shared definitions: op codes, ALUOp
// encodings, memory select codes and the mul/div FSM states.
package alu_ctrl_pkg;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_SLTU = 5'b01000;
  localparam logic [4:0] OP_SRA  = 5'b01100;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [2:0] RS_LW  = 3'b000;
  localparam logic [2:0] RS_LB  = 3'b001;
  localparam logic [2:0] RS_LBU = 3'b010;
  localparam logic [2:0] RS_LH  = 3'b011;
  localparam logic [2:0] RS_LHU = 3'b100;

  localparam logic [1:0] WS_SW = 2'b00;
  localparam logic [1:0] WS_SB = 2'b01;
  localparam logic [1:0] WS_SH = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MD_WAIT,
    S_MD_RESP
  } state_e;

  function automatic logic [4:0] m_code(input logic [2:0] f3);
    return {2'b10, f3};
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Decode-slot, result and mul/div handshake bundle of the
// ALU control stage.
interface alu_ctrl_if #(
  parameter int OP_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic            is_imm;
  logic            mem_read;
  logic            mem_write;
  logic            stall_in;
  logic            flush;
  logic            out_valid;
  logic [OP_W-1:0] operation;
  logic [2:0]      read_sel;
  logic [1:0]      write_sel;
  logic [2:0]      br_funct3;
  logic            illegal;
  logic            md_start;
  logic [2:0]      md_op;
  logic            md_abort;
  logic            md_done;
  logic            md_timeout;

  modport master (
    output in_valid, alu_op, funct7, funct3, is_imm,
    output mem_read, mem_write, stall_in, flush, md_done,
    input  in_ready, out_valid, operation, read_sel,
    input  write_sel, br_funct3, illegal,
    input  md_start, md_op, md_abort, md_timeout
  );

  modport slave (
    input  in_valid, alu_op, funct7, funct3, is_imm,
    input  mem_read, mem_write, stall_in, flush, md_done,
    output in_ready, out_valid, operation, read_sel,
    output write_sel, br_funct3, illegal,
    output md_start, md_op, md_abort, md_timeout
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct decode into op code, memory
// selects, branch condition, illegal and M-extension flags.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic       is_imm,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic [4:0] op_code,
  output logic [2:0] read_sel,
  output logic [1:0] write_sel,
  output logic [2:0] br_funct3,
  output logic       illegal,
  output logic       is_m
);

  logic alt;

  always_comb begin
    op_code   = OP_ADD;
    read_sel  = '0;
    write_sel = '0;
    br_funct3 = '0;
    illegal   = 1'b0;
    is_m      = 1'b0;
    alt       = 1'b0;
    unique case (1'b1)
      (alu_op == ALUOP_MEM): begin
        if (mem_read) begin
          case (funct3)
            3'b000:  read_sel = RS_LB;
            3'b001:  read_sel = RS_LH;
            3'b010:  read_sel = RS_LW;
            3'b100:  read_sel = RS_LBU;
            3'b101:  read_sel = RS_LHU;
            default: illegal = 1'b1;
          endcase
        end
        if (mem_write) begin
          case (funct3)
            3'b000:  write_sel = WS_SB;
            3'b001:  write_sel = WS_SH;
            3'b010:  write_sel = WS_SW;
            default: illegal = 1'b1;
          endcase
        end
      end
      (alu_op == ALUOP_BR): begin
        br_funct3 = funct3;
        case (funct3)
          3'b000, 3'b001: op_code = OP_SUB;
          3'b100, 3'b101: op_code = OP_SLT;
          3'b110, 3'b111: op_code = OP_SLTU;
          default:        illegal = 1'b1;
        endcase
      end
      (alu_op == ALUOP_ARITH): begin
        if (ENABLE_M && !is_imm && funct7 == F7_MD) begin
          is_m    = 1'b1;
          op_code = m_code(funct3);
        end else begin
          // Immediate forms only look at bit 5, and only for shifts
          if (is_imm) begin
            alt = (funct3 == 3'b101) && funct7[5];
          end else begin
            alt = (funct7 == F7_ALT);
            if (funct7 != F7_BASE && !alt)
              illegal = 1'b1;
            if (alt && funct3 != 3'b000 && funct3 != 3'b101)
              illegal = 1'b1;
          end
          case (funct3)
            3'b000:  op_code = alt ? OP_SUB : OP_ADD;
            3'b001:  op_code = OP_SLL;
            3'b010:  op_code = OP_SLT;
            3'b011:  op_code = OP_SLTU;
            3'b100:  op_code = OP_XOR;
            3'b101:  op_code = alt ? OP_SRA : OP_SRL;
            3'b110:  op_code = OP_OR;
            default: op_code = OP_AND;
          endcase
        end
      end
      (alu_op == ALUOP_ADD): op_code = OP_ADD;
      default: op_code = OP_ADD;
    endcase
    if (illegal) begin
      op_code   = OP_ADD;
      read_sel  = '0;
      write_sel = '0;
      br_funct3 = '0;
      is_m      = 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered ALU control stage at ID/EX with RV32M sequencing
// to an external iterative mul/div unit.
module alu_ctrl_stage
  import alu_ctrl_pkg::*;
#(
  parameter int OP_W       = 5,
  parameter bit ENABLE_M   = 1'b1,
  parameter int MD_TIMEOUT = 64
) (
  input logic       clk,
  input logic       reset,
  alu_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            out_valid_q, out_valid_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [2:0]      rs_q, rs_d;
  logic [1:0]      ws_q, ws_d;
  logic [2:0]      br_q, br_d;
  logic            ill_q, ill_d;
  logic            md_start_q, md_start_d;
  logic [2:0]      md_op_q, md_op_d;
  logic            md_abort_q, md_abort_d;
  logic            md_to_q, md_to_d;

  logic [4:0] dec_op;
  logic [2:0] dec_rs;
  logic [1:0] dec_ws;
  logic [2:0] dec_br;
  logic       dec_ill;
  logic       dec_is_m;
  logic       in_ready;
  logic       accept;
  logic       m_resp;

  alu_op_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .alu_op    (bus.alu_op),
    .funct7    (bus.funct7),
    .funct3    (bus.funct3),
    .is_imm    (bus.is_imm),
    .mem_read  (bus.mem_read),
    .mem_write (bus.mem_write),
    .op_code   (dec_op),
    .read_sel  (dec_rs),
    .write_sel (dec_ws),
    .br_funct3 (dec_br),
    .illegal   (dec_ill),
    .is_m      (dec_is_m)
  );

  assign in_ready = (state_q == S_IDLE) && !bus.stall_in;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    rs_d        = rs_q;
    ws_d        = ws_q;
    br_d        = br_q;
    ill_d       = ill_q;
    md_start_d  = 1'b0;
    md_op_d     = md_op_q;
    md_abort_d  = 1'b0;
    md_to_d     = md_to_q;
    m_resp      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          out_valid_d = 1'b0;
        end else if (accept && dec_is_m) begin
          md_start_d  = 1'b1;
          md_op_d     = bus.funct3;
          cnt_d       = '0;
          out_valid_d = 1'b0;
          state_d     = S_MD_WAIT;
        end else if (accept) begin
          out_valid_d = 1'b1;
          op_d        = OP_W'(dec_op);
          rs_d        = dec_rs;
          ws_d        = dec_ws;
          br_d        = dec_br;
          ill_d       = dec_ill;
        end else if (!bus.stall_in) begin
          out_valid_d = 1'b0;
        end
      end
      S_MD_WAIT: begin
        if (bus.flush) begin
          md_abort_d  = 1'b1;
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (bus.md_done) begin
          if (bus.stall_in) state_d = S_MD_RESP;
          else              m_resp  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(MD_TIMEOUT)) begin
            md_to_d     = 1'b1;
            md_abort_d  = 1'b1;
            out_valid_d = 1'b1;
            op_d        = OP_W'(OP_ADD);
            rs_d        = '0;
            ws_d        = '0;
            br_d        = '0;
            ill_d       = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
      S_MD_RESP: begin
        if (bus.flush) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else if (!bus.stall_in) begin
          m_resp = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (m_resp) begin
      out_valid_d = 1'b1;
      op_d        = OP_W'(m_code(md_op_q));
      rs_d        = '0;
      ws_d        = '0;
      br_d        = '0;
      ill_d       = 1'b0;
      state_d     = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      rs_q        <= '0;
      ws_q        <= '0;
      br_q        <= '0;
      ill_q       <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= '0;
      md_abort_q  <= 1'b0;
      md_to_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      ws_q        <= ws_d;
      br_q        <= br_d;
      ill_q       <= ill_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
      md_abort_q  <= md_abort_d;
      md_to_q     <= md_to_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.operation  = op_q;
  assign bus.read_sel   = rs_q;
  assign bus.write_sel  = ws_q;
  assign bus.br_funct3  = br_q;
  assign bus.illegal    = ill_q;
  assign bus.md_start   = md_start_q;
  assign bus.md_op      = md_op_q;
  assign bus.md_abort   = md_abort_q;
  assign bus.md_timeout = md_to_q;

endmodule
